// File: rtl/readout_iq_acc_pkg.sv
// Shared types, default widths and the sign-extension helper for the
// readout I/Q accumulator.
package readout_iq_acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      WR   = 2'd2
   } state_t;

   localparam int B_DEF          = 16;
   localparam int N_ACC_DEF      = 32;
   localparam int LEN_W_DEF      = 16;
   localparam int FIFO_DEPTH_DEF = 4;

   // Sign-extends the low w bits of v to 64 bits; callers narrow the result.
   function automatic logic [63:0] sext(input logic [63:0] v, input int w);
      logic signed [63:0] t;
      t = $signed(v << (64 - w));
      return t >>> (64 - w);
   endfunction

endpackage

// File: rtl/acc_result_fifo.sv
// Result FIFO with a registered head output; the presented entry stays in
// storage until popped, so DEPTH counts the entry on the output.
module acc_result_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_next;
   logic [AW:0]   count;
   logic [AW:0]   left;
   logic          wr_en;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign wr_en   = push & (~full | pop);
   assign rd_next = rd_ptr + AW'(pop);
   assign left    = count - (AW+1)'(pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // The head register only sees entries stored before this edge, so a
   // push into an empty FIFO is presented one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_next;
         count  <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
         valid  <= (left != '0);
         dout   <= mem[rd_next];
      end
   end

endmodule

// File: rtl/readout_iq_accumulator.sv
// Triggered windowed I/Q summation of the decimated readout stream; each
// finished {Q,I} sum pair is queued and streamed out on AXI-Stream.
module readout_iq_accumulator
   import readout_iq_acc_pkg::*;
#(
   parameter int B          = B_DEF,
   parameter int N_ACC      = N_ACC_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic               aclk,
   input  logic               areset,
   input  logic [2*B-1:0]     s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               trigger,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_we,
   output logic [2*N_ACC-1:0] m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               busy,
   output logic               overflow,
   output logic               missed
);

   state_t                  state;
   logic [LEN_W-1:0]        len_reg;
   logic [LEN_W-1:0]        shadow;
   logic [LEN_W-1:0]        cnt;
   logic signed [N_ACC-1:0] acc_i;
   logic signed [N_ACC-1:0] acc_q;
   logic                    beat;
   logic                    start;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign s_axis_tready = ~areset;
   assign beat          = s_axis_tvalid & ~areset;
   assign start         = (state == IDLE) && trigger && (len_reg != '0);
   assign push          = (state == WR);
   assign pop           = m_axis_tvalid & m_axis_tready & ~fifo_empty;

   // shadow mirrors len_reg except while a write made mid-window is pending,
   // so WR can always reload len_reg from it.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= IDLE;
         cnt      <= '0;
         len_reg  <= '0;
         shadow   <= '0;
         busy     <= 1'b0;
         missed   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (cfg_we) shadow <= cfg_len;

         if (trigger && state != IDLE) missed <= 1'b1;
         else if (cfg_we)              missed <= 1'b0;

         if (push && fifo_full && !pop) overflow <= 1'b1;
         else if (cfg_we)               overflow <= 1'b0;

         case (state)
            IDLE: begin
               if (cfg_we && !start) len_reg <= cfg_len;
               if (start) begin
                  state <= ACC;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ACC: begin
               if (beat) begin
                  cnt <= cnt + LEN_W'(1);
                  if (cnt == len_reg - LEN_W'(1)) state <= WR;
               end
            end
            WR: begin
               state   <= IDLE;
               busy    <= 1'b0;
               len_reg <= cfg_we ? cfg_len : shadow;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (start) begin
         acc_i <= '0;
         acc_q <= '0;
      end else if (state == ACC && beat) begin
         acc_i <= acc_i + N_ACC'(sext(64'(s_axis_tdata[B-1:0]), B));
         acc_q <= acc_q + N_ACC'(sext(64'(s_axis_tdata[2*B-1:B]), B));
      end
   end

   acc_result_fifo #(
      .W     (2*N_ACC),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (aclk),
      .rst   (areset),
      .push  (push),
      .pop   (pop),
      .din   ({acc_q, acc_i}),
      .dout  (m_axis_tdata),
      .valid (m_axis_tvalid),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_readout_iq_accumulator.sv
// Directed bench for readout_iq_accumulator with an 18-bit accumulator so
// wraparound is reachable with 16-bit samples.
module tb_readout_iq_accumulator;

   localparam int B  = 16;
   localparam int NA = 18;
   localparam int LW = 16;

   logic            aclk = 1'b0;
   logic            areset;
   logic [2*B-1:0]  s_axis_tdata;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic            trigger;
   logic [LW-1:0]   cfg_len;
   logic            cfg_we;
   logic [2*NA-1:0] m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            busy;
   logic            overflow;
   logic            missed;

   int n_assert = 0;
   int n_fail   = 0;

   readout_iq_accumulator #(
      .B          (B),
      .N_ACC      (NA),
      .LEN_W      (LW),
      .FIFO_DEPTH (4)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .trigger       (trigger),
      .cfg_len       (cfg_len),
      .cfg_we        (cfg_we),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .overflow      (overflow),
      .missed        (missed)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_beat(input int i, input int q);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {B'(q), B'(i)};
   endtask

   task automatic cfg(input int len);
      cfg_len = LW'(len);
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
   endtask

   task automatic pop_one();
      m_axis_tready = 1'b1;
      tick();
      m_axis_tready = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      #2;
      n_assert++;
      if ({s_axis_tready, m_axis_tvalid, busy, overflow, missed} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {s_axis_tready, m_axis_tvalid, busy, overflow, missed});
      end
      n_assert++;
      if (m_axis_tdata !== '0) begin
         n_fail++;
         $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata);
      end
      tick();
      tick();
      areset = 1'b0;
      tick();
      n_assert++;
      if (s_axis_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL tready_after_reset: got %b expected 1", s_axis_tready);
      end
   endtask

   task automatic test_basic();
      int busy_cycles = 0;
      logic [2*NA-1:0] exp = {NA'(-10), NA'(10)};
      cfg(4);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      if (busy) busy_cycles++;
      for (int k = 1; k <= 4; k++) begin
         set_beat(k, -k);
         tick();
         if (busy) busy_cycles++;
      end
      s_axis_tvalid = 1'b0;
      tick();
      if (busy) busy_cycles++;
      n_assert++;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_latency_early: got tvalid %b expected 0", m_axis_tvalid);
      end
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency: got tvalid %b expected 1", m_axis_tvalid);
      end
      n_assert++;
      if (m_axis_tdata !== exp) begin
         n_fail++;
         $display("FAIL basic_sum: got %h expected %h", m_axis_tdata, exp);
      end
      n_assert++;
      if (busy_cycles != 5) begin
         n_fail++;
         $display("FAIL basic_busy_cycles: got %0d expected 5", busy_cycles);
      end
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
         n_fail++;
         $display("FAIL basic_hold: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, exp);
      end
      pop_one();
      n_assert++;
      if (m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_pop: got tvalid %b expected 0", m_axis_tvalid);
      end
   endtask

   task automatic test_gapped();
      logic [2*NA-1:0] exp = {NA'(0), NA'(15)};
      cfg(3);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_beat(5, 0);
         s_axis_tvalid = (k % 2 == 0);
         tick();
      end
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
         n_fail++;
         $display("FAIL gapped_sum: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, exp);
      end
      pop_one();
   endtask

   task automatic test_wrap();
      logic [2*NA-1:0] exp = {NA'(98304), NA'(-98309)};
      cfg(5);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_beat(32767, -32768);
         tick();
      end
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
         n_fail++;
         $display("FAIL wrap_sum: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, exp);
      end
      pop_one();
   endtask

   task automatic test_overflow();
      int n = 0;
      logic [2*NA-1:0] exp;
      m_axis_tready = 1'b0;
      cfg(2);
      for (int w = 1; w <= 5; w++) begin
         trigger = 1'b1;
         tick();
         trigger = 1'b0;
         set_beat(w, 0);
         tick();
         set_beat(w, 0);
         tick();
         s_axis_tvalid = 1'b0;
         tick();
      end
      n_assert++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_set: got %b expected 1", overflow);
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (m_axis_tvalid === 1'b1) begin
            if (n < 4) begin
               exp = {NA'(0), NA'(2 * (n + 1))};
               n_assert++;
               if (m_axis_tdata !== exp) begin
                  n_fail++;
                  $display("FAIL overflow_order[%0d]: got %h expected %h", n, m_axis_tdata, exp);
               end
            end
            n++;
         end
         tick();
      end
      m_axis_tready = 1'b0;
      n_assert++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL overflow_count: got %0d results expected 4", n);
      end
      n_assert++;
      if (overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow_sticky: got %b expected 1", overflow);
      end
      cfg(2);
      n_assert++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear: got %b expected 0", overflow);
      end
   endtask

   task automatic test_missed();
      int n = 0;
      logic [2*NA-1:0] exp = {NA'(0), NA'(8)};
      cfg(8);
      trigger = 1'b1;
      tick();
      for (int k = 1; k <= 8; k++) begin
         set_beat(1, 0);
         trigger = (k == 3);
         tick();
      end
      trigger = 1'b0;
      s_axis_tvalid = 1'b0;
      n_assert++;
      if (missed !== 1'b1) begin
         n_fail++;
         $display("FAIL missed_set: got %b expected 1", missed);
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (m_axis_tvalid === 1'b1) begin
            if (n == 0) begin
               n_assert++;
               if (m_axis_tdata !== exp) begin
                  n_fail++;
                  $display("FAIL missed_sum: got %h expected %h", m_axis_tdata, exp);
               end
            end
            n++;
         end
         tick();
      end
      m_axis_tready = 1'b0;
      n_assert++;
      if (n != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL missed_single: got %0d results busy %b expected 1 results busy 0", n, busy);
      end
   endtask

   task automatic test_reset_mid_window();
      logic [2*NA-1:0] exp = {NA'(0), NA'(14)};
      cfg(4);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      set_beat(3, 3);
      tick();
      tick();
      areset = 1'b1;
      #1;
      n_assert++;
      if ({s_axis_tready, m_axis_tvalid, busy, overflow, missed} !== 5'b0 || m_axis_tdata !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got %b/%h expected 00000/0",
                  {s_axis_tready, m_axis_tvalid, busy, overflow, missed}, m_axis_tdata);
      end
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      areset = 1'b0;
      tick();
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_discard: got tvalid %b busy %b expected 0 0", m_axis_tvalid, busy);
      end
      cfg(2);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      set_beat(7, 0);
      tick();
      tick();
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
         n_fail++;
         $display("FAIL reset_resume: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, exp);
      end
      pop_one();
   endtask

   task automatic test_zero_len_and_cfg();
      logic [2*NA-1:0] exp2 = {NA'(0), NA'(2)};
      logic [2*NA-1:0] exp6 = {NA'(0), NA'(6)};
      cfg(0);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      n_assert++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len_busy: got %b expected 0", busy);
      end
      set_beat(9, 9);
      tick();
      tick();
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      n_assert++;
      if ({m_axis_tvalid, busy, missed} !== 3'b000) begin
         n_fail++;
         $display("FAIL zero_len_idle: got %b expected 000", {m_axis_tvalid, busy, missed});
      end
      cfg(2);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      set_beat(1, 0);
      cfg_len = LW'(6);
      cfg_we  = 1'b1;
      tick();
      cfg_we  = 1'b0;
      tick();
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp2) begin
         n_fail++;
         $display("FAIL cfg_current_window: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, exp2);
      end
      pop_one();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_beat(1, 0);
         tick();
         if (k == 4) begin
            n_assert++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL cfg_next_busy: got %b expected 1", busy);
            end
         end
      end
      s_axis_tvalid = 1'b0;
      tick();
      tick();
      n_assert++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp6) begin
         n_fail++;
         $display("FAIL cfg_next_window: got %b/%h expected 1/%h", m_axis_tvalid, m_axis_tdata, exp6);
      end
      pop_one();
   endtask

   initial begin
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      trigger       = 1'b0;
      cfg_len       = '0;
      cfg_we        = 1'b0;
      m_axis_tready = 1'b0;
      test_reset();
      test_basic();
      test_gapped();
      test_wrap();
      test_overflow();
      test_missed();
      test_reset_mid_window();
      test_zero_len_and_cfg();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/readout_iq_accumulator.md
# readout_iq_accumulator

Downstream companion to the readout stage. Consumes the decimated 32-bit {Q,I} sample stream from the readout's M1_AXIS output and, on each trigger, sums a programmed number of valid I and Q samples. Each finished sum pair is written into a small result FIFO. Results leave on an AXI-Stream master toward the DMA/buffer stage.

## Interface
Parameters:
- B, 16: width of each input component (I, Q), signed.
- N_ACC, 32: width of each accumulator, signed; must be ≥ B.
- LEN_W, 16: width of the window length.
- FIFO_DEPTH, 4: number of result entries; must be a power of 2.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  2*B  [B-1:0] = I, [2B-1:B] = Q.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  0 while in reset, 1 otherwise; input is never stalled.
- trigger  in  1  single-cycle start pulse.
- cfg_len  in  LEN_W  window length in valid beats.
- cfg_we  in  1  loads cfg_len into the shadow register and clears the sticky flags.
- m_axis_tdata  out  2*N_ACC  [N_ACC-1:0] = sum of I, upper half = sum of Q.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accept.
- busy  out  1  high in the ACC and WR states.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- missed  out  1  sticky: a trigger arrived while busy.

## Operation
- **State machine: IDLE, ACC, WR.**
- **IDLE**
  - trigger with len_reg ≠ 0: clear the accumulators and counter, go to ACC.
  - trigger with len_reg = 0: ignored; no state change, no flag set.
- **ACC**
  - Each beat with s_axis_tvalid = 1: add the sign-extended I and Q to the accumulators; cnt++.
  - Beats with tvalid = 0 are not counted.
  - When the beat with cnt = len_reg − 1 is accepted, go to WR.
- **WR** (one cycle)
  - Push {acc_q, acc_i} into the FIFO, then go to IDLE.
  - If the FIFO is full and no pop happens in the same cycle: the result is dropped and overflow is set.
- **Trigger handling**
  - A trigger in ACC or WR is ignored and sets missed.
  - A trigger in IDLE on the same cycle as a valid beat: that beat is NOT summed; summing starts with beats on the following cycles.
- **Arithmetic:** two's complement. Sums wrap modulo 2^N_ACC; there is no saturation.
- **cfg_we**
  - Accepted in any state.
  - The new length is latched into len_reg only while in IDLE. If cfg_we arrives in ACC/WR, the shadow value is copied into len_reg on return to IDLE. The running window keeps its length.
  - cfg_we clears overflow and missed. If cfg_we and a set event occur in the same cycle, the set wins.
- **FIFO**
  - First-in, first-out.
  - Push and pop in the same cycle when full: both happen and no overflow is flagged.
  - Pop in the same cycle as push when empty: not allowed. The pushed entry appears next cycle.

## Timing
- **Reset values (immediate, asynchronous):**
  - state = IDLE; busy = 0; m_axis_tvalid = 0; m_axis_tdata = 0.
  - overflow = 0; missed = 0; s_axis_tready = 0.
  - len_reg = 0; FIFO empty.
- **Reset during ACC:** the window is discarded and nothing is emitted.
- **Latency:** when the last beat is accepted at edge k, the push occurs at edge k+1 and m_axis_tvalid is high after edge k+2, provided the FIFO was empty.
- **busy:** rises the cycle after trigger and falls after the WR edge.
- **Output handshake:**
  - m_axis_tdata is stable while m_axis_tvalid = 1 and m_axis_tready = 0.
  - A pop happens on an edge where both are 1.
  - The next entry is presented on the following cycle (registered FIFO output; no bubble while the FIFO is not empty).
- **Back-to-back windows:** a trigger may be accepted on the cycle after WR (in IDLE), so the minimum trigger spacing is len + 2 cycles.

## Structure
- **Package `readout_iq_acc_pkg`:** state enum {IDLE, ACC, WR}, the default width constants, and the accumulator sign-extension function.
- **Sub-module `acc_result_fifo`:** synchronous FIFO with registered output, full/empty flags and an async active-high reset. Width 2*N_ACC, depth FIFO_DEPTH.
- **Top level:** FSM, counter, accumulators and sticky flags.

## Test plan
- **Basic sum:** cfg_len = 4; trigger; I = 1, 2, 3, 4 and Q = −1, −2, −3, −4 on consecutive cycles → one result with I = 10, Q = −10, tvalid high 2 cycles after the last beat; busy high for 5 cycles.
- **Gapped input:** cfg_len = 3; tvalid pattern 1, 0, 1, 0, 1 with I = 5 on every cycle (Q = 0) → I = 15, Q = 0; invalid beats are ignored.
- **Wrap:** bench uses N_ACC = 18; cfg_len = 5; I = 32767 on every beat → I = −98309; Q = −32768 on every beat → Q = 98304.
- **Backpressure/overflow:** m_axis_tready = 0; cfg_len = 2; 5 triggers spaced 4 cycles apart, with I = window index (1 to 5) → overflow = 1. After tready = 1, exactly 4 results come out with I = 2, 4, 6, 8 in order. The cfg_we pulse clears overflow.
- **Missed trigger and reset:**
  - cfg_len = 8; a second trigger at beat 3 → missed = 1 and exactly one result is produced.
  - Assert areset mid-window → all outputs are 0 immediately. After release, cfg_len = 2 with I = 7, 7 → I = 14.
- **Zero length / config timing:** cfg_len = 0 then trigger → no busy, no result. cfg_we with cfg_len = 6 during a window of length 2 → the current result uses 2 beats; the next window uses 6 beats.
